// File: rtl/ellipse_scene_sequencer.sv
// Front-end controller for a daisy chain of ellipse renderers.
// Turns shape commands into five-word register programs for one renderer slot,
// sweeps raster frames of pixel coordinates through the chain on request, and
// provides a pixel-valid strobe plus a copy aligned to the chain output.
module ellipse_scene_sequencer #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned N_SLOTS   = 4,
  parameter int unsigned CHAIN_LAT = 20,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_slot,
  input  logic [11:0] cmd_x,
  input  logic [11:0] cmd_y,
  input  logic [11:0] cmd_wrad,
  input  logic [11:0] cmd_hrad,
  input  logic [11:0] cmd_color,
  output logic        program_out,
  output logic [11:0] x_out,
  output logic [11:0] y_out,
  output logic [11:0] data_out,
  output logic        pix_valid,
  output logic        tail_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        cmd_err
);

  localparam logic [11:0] XLast     = 12'(H_RES - 1);
  localparam logic [11:0] YLast     = 12'(V_RES - 1);
  localparam int unsigned DrainW    = (CHAIN_LAT > 1) ? $clog2(CHAIN_LAT) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(CHAIN_LAT - 1);
  localparam logic [2:0]  ProgLast  = 3'd4;

  typedef enum logic [1:0] {StIdle, StProg, StScan, StDrain} state_e;

  state_e state_q, state_d;

  // Latched command
  logic [11:0] slot_q, slot_d;
  logic [11:0] cx_q, cx_d;
  logic [11:0] cy_q, cy_d;
  logic [11:0] wrad_q, wrad_d;
  logic [11:0] hrad_q, hrad_d;
  logic [11:0] color_q, color_d;

  // Sequencing counters
  logic [2:0]        idx_q, idx_d;
  logic [11:0]       px_q, px_d;
  logic [11:0]       py_q, py_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              pending_q, pending_d;

  // Registered outputs
  logic              program_q, program_d;
  logic [11:0]       xo_q, xo_d;
  logic [11:0]       yo_q, yo_d;
  logic [11:0]       data_q, data_d;
  logic              pix_q, pix_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CHAIN_LAT-1:0] tail_q, tail_d;

  logic        slot_legal;
  logic [2:0]  idx_next;
  logic [11:0] next_word;

  assign slot_legal = 32'(cmd_slot) < N_SLOTS;
  assign idx_next   = idx_q + 3'd1;

  // Value of the program word following the one currently on the outputs
  always_comb begin
    next_word = color_q;
    case (idx_next)
      3'd1:    next_word = cy_q;
      3'd2:    next_word = wrad_q;
      3'd3:    next_word = hrad_q;
      default: next_word = color_q;
    endcase
  end

  // Next-state, counter and output-word decode
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    wrad_d    = wrad_q;
    hrad_d    = hrad_q;
    color_d   = color_q;
    idx_d     = idx_q;
    px_d      = px_q;
    py_d      = py_q;
    drain_d   = drain_q;
    pending_d = pending_q;
    program_d = 1'b0;
    xo_d      = 12'd0;
    yo_d      = 12'd0;
    data_d    = BG_COLOR;
    pix_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          // A command always wins over start; start is kept as pending
          pending_d = pending_q | start;
          if (slot_legal) begin
            slot_d    = cmd_slot;
            cx_d      = cmd_x;
            cy_d      = cmd_y;
            wrad_d    = cmd_wrad;
            hrad_d    = cmd_hrad;
            color_d   = cmd_color;
            idx_d     = 3'd0;
            state_d   = StProg;
            program_d = 1'b1;
            xo_d      = cmd_slot;
            yo_d      = 12'd0;
            data_d    = cmd_x;
          end else begin
            err_d = 1'b1;
          end
        end else if (start || pending_q) begin
          pending_d = 1'b0;
          px_d      = 12'd0;
          py_d      = 12'd0;
          state_d   = StScan;
          pix_d     = 1'b1;
        end
      end

      StProg: begin
        pending_d = pending_q | start;
        if (idx_q == ProgLast) begin
          state_d = StIdle;
        end else begin
          idx_d     = idx_next;
          program_d = 1'b1;
          xo_d      = slot_q;
          yo_d      = {9'd0, idx_next};
          data_d    = next_word;
        end
      end

      StScan: begin
        pending_d = pending_q | start;
        if (px_q == XLast && py_q == YLast) begin
          drain_d = '0;
          px_d    = 12'd0;
          py_d    = 12'd0;
          state_d = StDrain;
        end else begin
          if (px_q == XLast) begin
            px_d = 12'd0;
            py_d = py_q + 12'd1;
          end else begin
            px_d = px_q + 12'd1;
          end
          pix_d = 1'b1;
          xo_d  = px_d;
          yo_d  = py_d;
        end
      end

      StDrain: begin
        pending_d = pending_q | start;
        if (drain_q == DrainLast) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // Delay line that shifts the registered pixel strobe towards the chain tail
  always_comb begin
    tail_d    = tail_q;
    tail_d[0] = pix_q;
    for (int i = 1; i < int'(CHAIN_LAT); i++) begin
      tail_d[i] = tail_q[i-1];
    end
  end

  // State, counters and registered outputs; synchronous reset aborts everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      slot_q    <= 12'd0;
      cx_q      <= 12'd0;
      cy_q      <= 12'd0;
      wrad_q    <= 12'd0;
      hrad_q    <= 12'd0;
      color_q   <= 12'd0;
      idx_q     <= 3'd0;
      px_q      <= 12'd0;
      py_q      <= 12'd0;
      drain_q   <= '0;
      pending_q <= 1'b0;
      program_q <= 1'b0;
      xo_q      <= 12'd0;
      yo_q      <= 12'd0;
      data_q    <= BG_COLOR;
      pix_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      wrad_q    <= wrad_d;
      hrad_q    <= hrad_d;
      color_q   <= color_d;
      idx_q     <= idx_d;
      px_q      <= px_d;
      py_q      <= py_d;
      drain_q   <= drain_d;
      pending_q <= pending_d;
      program_q <= program_d;
      xo_q      <= xo_d;
      yo_q      <= yo_d;
      data_q    <= data_d;
      pix_q     <= pix_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tail_q    <= tail_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle) && !rst;
  assign program_out = program_q;
  assign x_out       = xo_q;
  assign y_out       = yo_q;
  assign data_out    = data_q;
  assign pix_valid   = pix_q;
  assign tail_valid  = tail_q[CHAIN_LAT-1];
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign cmd_err     = err_q;

endmodule
